gpio16_wb: RTL and testbench
============================

Name: gpio16_wb

Overview:
Wishbone-slave GPIO controller for the 16 user pads io[23:8]. It sits directly downstream of the Caravel wishbone port inside user_project and drives that module's io_out/io_oeb/irq outputs. Features:
- per-pin direction and output registers
- 2-flop input synchronisation
- per-pin edge-detect interrupts with sticky status

Parameters:
- NPINS, 16, number of GPIO pins; legal range 1..32.
- BASE_ADDR, 32'h3000_0000, wishbone base address; decode compares adr[31:8] against BASE_ADDR[31:8].
- DEBOUNCE_CYCLES, 4, stable-sample count used only when GPIO_DEBOUNCE_EN is defined; legal range 2..255.

Ports:
- wb_clk_i  input  1  system clock; all state updates on rising edge.
- wb_rst_n  input  1  asynchronous active-low reset; the parent drives it as ~wb_rst_i.
- wbs_cyc_i  input  1  wishbone cycle.
- wbs_stb_i  input  1  wishbone strobe.
- wbs_we_i  input  1  write enable.
- wbs_sel_i  input  4  byte selects.
- wbs_adr_i  input  32  byte address.
- wbs_dat_i  input  32  write data.
- wbs_ack_o  output  1  acknowledge.
- wbs_dat_o  output  32  read data.
- io_in  input  NPINS  pad inputs.
- io_out  output  NPINS  pad output values.
- io_oeb  output  NPINS  pad output-enable, active-low.
- irq  output  1  level interrupt; the parent maps it to irq[0] and ties irq[2:1] to 0.

Behaviour:

Reset values:
- wbs_ack_o=0, wbs_dat_o=0, io_out=0, io_oeb=all 1s (all pins input), irq=0.
- All registers and synchroniser flops are 0.

Register map (offset from BASE_ADDR; bits above NPINS read 0 and ignore writes):
- 0x00 DATA_IN, RO: synchronised pin values.
- 0x04 DATA_OUT, RW: drives io_out.
- 0x08 DIR, RW: 1 = output. io_oeb = ~DIR.
- 0x0C IRQ_EN, RW: per-pin interrupt enable.
- 0x10 IRQ_STAT, R/W1C: sticky edge flags.
- 0x14 EDGE_SEL, RW: 1 = rising edge, 0 = falling edge.
- Other offsets within the 256-byte window: reads return 0, writes are ignored, ack is still given.

Wishbone handshake:
- Access is valid when cyc & stb & address hit & ~ack.
- wbs_ack_o is registered: it asserts for exactly one cycle, one clock after the valid access.
- Ack is forced low in the cycle following an ack, so each transfer takes 2 cycles minimum.
- wbs_dat_o is registered in the same cycle as ack and is returned to 0 when ack is low.
- Writes honour wbs_sel_i per byte and take effect in the ack cycle.
- An address miss produces no ack and no state change.

Input path and interrupts:
- sync1 <= io_in; sync2 <= sync1; prev <= sync2.
- DATA_IN = sync2, so a pad change is readable 2 clocks later.
- Edge detection: rise = sync2 & ~prev; fall = ~sync2 & prev; edge = EDGE_SEL ? rise : fall.
- IRQ_STAT[i] sets on the clock after edge[i] is detected, regardless of IRQ_EN.
- irq = |(IRQ_STAT & IRQ_EN), combinational from registers. A pad edge therefore raises irq on the 3rd rising clock after the change.

Boundary cases:
- A W1C clear and a new edge on the same bit in the same cycle: set wins, bit stays 1.
- A write to EDGE_SEL does not itself generate an edge; prev is unaffected.
- Changing DIR does not alter DATA_OUT.
- Input pins still feed DATA_IN and edge detection when configured as outputs, which gives loopback.
- Reset asserted mid-transfer: ack and dat drop immediately (async). The master must retry the transfer after reset.

Optional Feature:
GPIO_DEBOUNCE_EN
- Defined: each pin gets an 8-bit stability counter on sync2.
  - The filtered value updates only after sync2 has differed from the filtered value for DEBOUNCE_CYCLES consecutive clocks.
  - The counter resets to 0 on any sample equal to the filtered value.
  - DATA_IN and edge detection use the filtered value, adding DEBOUNCE_CYCLES clocks of latency.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Undefined: no filter, and the latencies are as stated above.

Test Plan:
1. Reset, then read 0x08 and 0x04 → 0. io_oeb=16'hFFFF, io_out=0, irq=0. Each read's ack is high for exactly 1 cycle.
2. Write DIR=16'h00FF, then DATA_OUT=16'hA5A5 with sel=4'b0001 → io_oeb=16'hFF00, io_out=16'h00A5.
3. Drive io_in=16'h0010 → read DATA_IN=16'h0010 no earlier than 2 clocks after the change.
4. Set EDGE_SEL[4]=1 and IRQ_EN[4]=1, then drive a 0→1 edge on pin 4 → irq high on the 3rd clock and IRQ_STAT=16'h0010. Write 0x10=16'h0010 → irq low next cycle.
5. Issue a W1C on bit 4 in the same cycle a new rising edge on pin 4 is detected → IRQ_STAT[4] remains 1 and irq stays high.
6. Access BASE_ADDR+0x100 → no ack. Access offset 0x20 → ack with data 0. Assert wb_rst_n=0 while ack=1 → ack drops without waiting for a clock.

Source files
------------

// File: rtl/gpio16_wb.sv
// Wishbone-slave GPIO controller: per-pin direction/output registers, 2-flop input sync, edge IRQs with sticky W1C status.
// Latency: ack and read data registered one clock after a valid access; pad change readable after 2 clocks, irq after 3.
// Backpressure: none; every address hit is acked, ack self-clears so each transfer occupies at least 2 cycles.
//
// Optional feature macro: GPIO_DEBOUNCE_EN inserts a per-pin stability filter (DEBOUNCE_CYCLES clocks) after the synchroniser.
// Ports:
//   wb_clk_i, wb_rst_n          clock, asynchronous active-low reset
//   wbs_cyc/stb/we/sel/adr/dat  wishbone slave request, wbs_ack_o/wbs_dat_o response
//   io_in, io_out, io_oeb       pad input, pad output value, pad output-enable (active-low)
//   irq                         level interrupt, OR of enabled sticky status bits
module gpio16_wb #(
    parameter int unsigned NPINS           = 16,
    parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [NPINS-1:0] io_in,
    output logic [NPINS-1:0] io_out,
    output logic [NPINS-1:0] io_oeb,
    output logic             irq
);

    // Word indices within the 256-byte window
    localparam logic [5:0] W_DATA_IN  = 6'd0;
    localparam logic [5:0] W_DATA_OUT = 6'd1;
    localparam logic [5:0] W_DIR      = 6'd2;
    localparam logic [5:0] W_IRQ_EN   = 6'd3;
    localparam logic [5:0] W_IRQ_STAT = 6'd4;
    localparam logic [5:0] W_EDGE_SEL = 6'd5;

    if (NPINS < 1 || NPINS > 32) begin : g_bad_npins
        $error("gpio16_wb: NPINS must be 1..32");
    end
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("gpio16_wb: DEBOUNCE_CYCLES must be 2..255");
    end

    logic             r_ack;
    logic [31:0]      r_dat;
    logic [NPINS-1:0] r_data_out;
    logic [NPINS-1:0] r_dir;
    logic [NPINS-1:0] r_irq_en;
    logic [NPINS-1:0] r_irq_stat;
    logic [NPINS-1:0] r_edge_sel;
    logic [NPINS-1:0] r_sync1;
    logic [NPINS-1:0] r_sync2;
    logic [NPINS-1:0] r_prev;

    logic             w_hit;
    logic             w_valid;
    logic             w_wr;
    logic [5:0]       w_word;
    logic [31:0]      w_rdata;
    logic [NPINS-1:0] w_pin;
    logic [NPINS-1:0] w_edge;
    logic [NPINS-1:0] w_w1c;
    logic             w_unused_adr;

    // Byte-lane merge of write data into an NPINS-wide register; bits above NPINS are dropped.
    function automatic logic [NPINS-1:0] f_merge(input logic [NPINS-1:0] old_val,
                                                 input logic [31:0]      wdat,
                                                 input logic [3:0]       sel);
        logic [31:0] v;
        v = 32'(old_val);
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) v[8*b +: 8] = wdat[8*b +: 8];
        end
        return v[NPINS-1:0];
    endfunction

    assign w_hit        = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // ~r_ack blocks the cycle right after an ack, so a held request is not serviced twice
    assign w_valid      = wbs_cyc_i & wbs_stb_i & w_hit & ~r_ack;
    assign w_wr         = w_valid & wbs_we_i;
    assign w_word       = wbs_adr_i[7:2];
    assign w_unused_adr = ^wbs_adr_i[1:0];

`ifdef GPIO_DEBOUNCE_EN
    // Filtered value follows sync2 only after it has disagreed for DEBOUNCE_CYCLES consecutive clocks
    logic [NPINS-1:0] r_filt;
    logic [7:0]       r_cnt [NPINS];

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_filt <= '0;
            for (int i = 0; i < NPINS; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NPINS; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
                    r_filt[i] <= r_sync2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign w_pin = r_filt;
`else
    assign w_pin = r_sync2;
`endif

    assign w_edge = (r_edge_sel & w_pin & ~r_prev) | (~r_edge_sel & ~w_pin & r_prev);
    assign w_w1c  = (w_wr && w_word == W_IRQ_STAT) ? f_merge('0, wbs_dat_i, wbs_sel_i) : '0;

    always_comb begin
        w_rdata = '0;
        case (w_word)
            W_DATA_IN:  w_rdata = 32'(w_pin);
            W_DATA_OUT: w_rdata = 32'(r_data_out);
            W_DIR:      w_rdata = 32'(r_dir);
            W_IRQ_EN:   w_rdata = 32'(r_irq_en);
            W_IRQ_STAT: w_rdata = 32'(r_irq_stat);
            W_EDGE_SEL: w_rdata = 32'(r_edge_sel);
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_data_out <= '0;
            r_dir      <= '0;
            r_irq_en   <= '0;
            r_irq_stat <= '0;
            r_edge_sel <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_prev     <= '0;
        end else begin
            r_ack   <= w_valid;
            r_dat   <= (w_valid && !wbs_we_i) ? w_rdata : '0;
            r_sync1 <= io_in;
            r_sync2 <= r_sync1;
            r_prev  <= w_pin;
            if (w_wr && w_word == W_DATA_OUT) r_data_out <= f_merge(r_data_out, wbs_dat_i, wbs_sel_i);
            if (w_wr && w_word == W_DIR)      r_dir      <= f_merge(r_dir, wbs_dat_i, wbs_sel_i);
            if (w_wr && w_word == W_IRQ_EN)   r_irq_en   <= f_merge(r_irq_en, wbs_dat_i, wbs_sel_i);
            if (w_wr && w_word == W_EDGE_SEL) r_edge_sel <= f_merge(r_edge_sel, wbs_dat_i, wbs_sel_i);
            // Clear first, then OR in new edges: a simultaneous edge keeps the bit set
            r_irq_stat <= (r_irq_stat & ~w_w1c) | w_edge;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign io_out    = r_data_out;
    assign io_oeb    = ~r_dir;
    assign irq       = |(r_irq_stat & r_irq_en);

endmodule

// File: tb/tb_gpio16_wb.sv
module tb_gpio16_wb;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        cyc   = 1'b0;
    logic        stb   = 1'b0;
    logic        we    = 1'b0;
    logic [3:0]  sel   = 4'h0;
    logic [31:0] adr   = 32'h0;
    logic [31:0] dat_i = 32'h0;
    logic [15:0] io_in = 16'h0;
    logic        ack;
    logic [31:0] dat_o;
    logic [15:0] io_out;
    logic [15:0] io_oeb;
    logic        irq;

    gpio16_wb dut (
        .wb_clk_i  (clk),
        .wb_rst_n  (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_i),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_rd;
        logic [31:0] adr;
        logic [31:0] dat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops one expectation; reads also compare data
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ack) begin
            checks++;
            if (prev_ack) begin
                errors++;
                $display("FAIL ack_width: ack high for 2+ cycles, expected 1");
            end
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: ack with empty scoreboard, expected none");
            end else begin
                e = sb_q.pop_front();
                if (e.is_rd) begin
                    checks++;
                    if (dat_o !== e.dat) begin
                        errors++;
                        $display("FAIL rd_%h: got %h expected %h", e.adr, dat_o, e.dat);
                    end
                end
            end
        end
        prev_ack = rst_n && ack;
    end

    // Call at posedge+#1. For reads, d is the expected read data.
    task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        bit   got;
        e.is_rd = !w;
        e.adr   = a;
        e.dat   = d;
        sb_q.push_back(e);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = w ? d : 32'h0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) got = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL wb_timeout_%h: no ack, expected ack", a);
            sb_q.delete(sb_q.size() - 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        bit got;

        // 1. reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
        chk("rst_out", {16'h0, io_out}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_ack", {31'h0, ack}, 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        wb(1'b0, BASE + 32'h08, 32'h0, 4'hF);
        wb(1'b0, BASE + 32'h04, 32'h0, 4'hF);

        // 2. direction and output with byte selects
        wb(1'b1, BASE + 32'h08, 32'h0000_00FF, 4'hF);
        wb(1'b1, BASE + 32'h04, 32'h0000_A5A5, 4'b0001);
        chk("dir_oeb", {16'h0, io_oeb}, 32'h0000_FF00);
        chk("out_sel", {16'h0, io_out}, 32'h0000_00A5);
        wb(1'b0, BASE + 32'h04, 32'h0000_00A5, 4'hF);
        wb(1'b1, BASE + 32'h08, 32'h0000_0F00, 4'b0010);
        chk("dir_byte1_oeb", {16'h0, io_oeb}, 32'h0000_F000);
        chk("dir_keeps_out", {16'h0, io_out}, 32'h0000_00A5);

        // 3. input synchroniser latency
        @(posedge clk); #1;
        io_in = 16'h0010;
        wb(1'b0, BASE + 32'h00, 32'h0, 4'hF);
        wb(1'b0, BASE + 32'h00, 32'h0000_0010, 4'hF);

        // 4. rising-edge interrupt on pin 4, then W1C
        wb(1'b1, BASE + 32'h14, 32'h0000_0010, 4'hF);
        io_in = 16'h0000;
        repeat (4) @(posedge clk);
        #1;
        wb(1'b1, BASE + 32'h10, 32'h0000_FFFF, 4'hF);
        wb(1'b0, BASE + 32'h10, 32'h0, 4'hF);
        wb(1'b1, BASE + 32'h0C, 32'h0000_0010, 4'hF);
        chk("irq_before_edge", {31'h0, irq}, 32'h0);
        io_in = 16'h0010;
        @(posedge clk); #1 chk("irq_clk1", {31'h0, irq}, 32'h0);
        @(posedge clk); #1 chk("irq_clk2", {31'h0, irq}, 32'h0);
        @(posedge clk); #1 chk("irq_clk3", {31'h0, irq}, 32'h1);
        wb(1'b0, BASE + 32'h10, 32'h0000_0010, 4'hF);
        wb(1'b1, BASE + 32'h10, 32'h0000_0010, 4'hF);
        chk("irq_w1c", {31'h0, irq}, 32'h0);

        // 5. W1C and new edge in the same cycle: set wins
        io_in = 16'h0000;
        repeat (4) @(posedge clk);
        #1 chk("irq_fall_ignored", {31'h0, irq}, 32'h0);
        io_in = 16'h0010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wb(1'b1, BASE + 32'h10, 32'h0000_0010, 4'hF);
        chk("irq_set_wins", {31'h0, irq}, 32'h1);
        wb(1'b0, BASE + 32'h10, 32'h0000_0010, 4'hF);

        // 6. address miss, unmapped offset, reset during ack
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h100; sel = 4'hF;
        got = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack) got = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0;
        chk("miss_no_ack", {31'h0, got}, 32'h0);
        wb(1'b0, BASE + 32'h20, 32'h0, 4'hF);
        wb(1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF);
        wb(1'b0, BASE + 32'h04, 32'h0000_00A5, 4'hF);

        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h04; sel = 4'hF;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) got = 1'b1;
        end
        chk("rstmid_ack_pre", {31'h0, ack}, 32'h1);
        chk("rstmid_dat_pre", dat_o, 32'h0000_00A5);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_ack", {31'h0, ack}, 32'h0);
        chk("rstmid_dat", dat_o, 32'h0);
        chk("rstmid_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
        chk("rstmid_irq", {31'h0, irq}, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        wb(1'b0, BASE + 32'h04, 32'h0, 4'hF);

        repeat (3) @(posedge clk);
        #1 chk("sb_drained", sb_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
